// File: rtl/regfile_pkg.sv
// Shared constants for the MIPS register file: control levels and the
// reserved zero register index.
package regfile_pkg;

  localparam int RegBusW     = 32;
  localparam int RegAddrBusW = 5;
  localparam int RegNum      = 32;
  localparam int RegNumLog2  = 5;

  localparam logic [RegBusW-1:0]     ZeroWord     = '0;
  localparam logic [RegAddrBusW-1:0] NOPRegAddr   = 5'b00000;

  localparam logic RstnEnable   = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;

endpackage

// File: rtl/regfile_rport.sv
// One combinational read port: reset, r0, read-enable, write bypass, then
// array contents, in that priority order.
module regfile_rport
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] regval,
  output logic [DATA_W-1:0] rdata
);

  always_comb begin
    rdata = '0;
    if (rst == RstnEnable) begin
      rdata = '0;
    end else if (raddr == '0) begin
      rdata = '0;
    end else if (re == ReadDisable) begin
      rdata = '0;
    end else if ((we == WriteEnable) && (waddr == raddr)) begin
      // Result being written back this cycle reaches decode without waiting.
      rdata = wdata;
    end else begin
      rdata = regval;
    end
  end

endmodule

// File: rtl/regfile.sv
// 32 x 32 MIPS general-purpose register file: one write port from
// write-back, two combinational read ports into decode with bypass.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int REG_NUM = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] r_regs [REG_NUM];
  logic [DATA_W-1:0] w_regval1;
  logic [DATA_W-1:0] w_regval2;

  // Reset clears the whole array and overrides any write in the same cycle;
  // index 0 is never written so it stays zero.
  always_ff @(posedge clk) begin
    if (rst == RstnEnable) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= '0;
      end
    end else if ((we == WriteEnable) && (waddr != '0)) begin
      r_regs[waddr] <= wdata;
    end
  end

  assign w_regval1 = r_regs[raddr1];
  assign w_regval2 = r_regs[raddr2];

  regfile_rport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rport1 (
    .rst    (rst),
    .re     (re1),
    .raddr  (raddr1),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .regval (w_regval1),
    .rdata  (rdata1)
  );

  regfile_rport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rport2 (
    .rst    (rst),
    .re     (re2),
    .raddr  (raddr2),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .regval (w_regval2),
    .rdata  (rdata2)
  );

endmodule

// File: tb/tb_regfile.sv
// Directed bench for the register file: reset, write/read, bypass, r0,
// full-array sweep and reset-over-write.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

  int n_cmp;
  int n_err;

  regfile #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .REG_NUM (32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] e1;
    logic [31:0] e2;
    n_cmp = 0;
    n_err = 0;

    // 1: reset with a pending write to r5
    rst = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
    #1;
    check("rst_t0_rd1", rdata1, 32'h0);
    check("rst_t0_rd2", rdata2, 32'h0);
    tick();
    check("rst_c1_rd1", rdata1, 32'h0);
    tick();
    check("rst_c2_rd2", rdata2, 32'h0);
    rst = 1'b1; we = 1'b0;
    #1;
    check("rst_r5_clear", rdata1, 32'h0);
    check("rst_r5_clear_p2", rdata2, 32'h0);

    // 2: write then read r3; read-enable gating
    we = 1'b1; waddr = 5'd3; wdata = 32'h12345678;
    tick();
    we = 1'b0; raddr1 = 5'd3; re1 = 1'b1;
    #1;
    check("wr_r3", rdata1, 32'h12345678);
    re1 = 1'b0;
    #1;
    check("re1_off", rdata1, 32'h0);
    we = 1'b1; waddr = 5'd3; wdata = 32'hCAFEF00D;
    #1;
    check("re1_off_bypass", rdata1, 32'h0);
    we = 1'b0;

    // 3: same-cycle bypass on both ports, then array value
    re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd7; raddr2 = 5'd7;
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
    #1;
    check("byp_rd1", rdata1, 32'hA5A5A5A5);
    check("byp_rd2", rdata2, 32'hA5A5A5A5);
    tick();
    we = 1'b0;
    #1;
    check("arr_r7_rd1", rdata1, 32'hA5A5A5A5);
    check("arr_r7_rd2", rdata2, 32'hA5A5A5A5);

    // 4: writes to r0 are discarded and never bypassed
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    check("r0_byp_rd1", rdata1, 32'h0);
    check("r0_byp_rd2", rdata2, 32'h0);
    tick();
    we = 1'b0;
    #1;
    check("r0_after_rd1", rdata1, 32'h0);

    // 5: fill every register, sweep pairs (i, 31-i)
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'(i) * 32'h01010101;
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      e1 = 32'(i) * 32'h01010101;
      e2 = 32'(31 - i) * 32'h01010101;
      #1;
      check($sformatf("sweep_rd1_%0d", i), rdata1, e1);
      check($sformatf("sweep_rd2_%0d", 31 - i), rdata2, e2);
    end

    // Write to a third register leaves other reads untouched
    we = 1'b1; waddr = 5'd1; wdata = 32'h0BADBEEF; raddr1 = 5'd2; raddr2 = 5'd3;
    #1;
    check("third_rd1", rdata1, 32'h02020202);
    check("third_rd2", rdata2, 32'h03030303);
    raddr1 = 5'd1;
    #1;
    check("third_byp_rd1", rdata1, 32'h0BADBEEF);
    we = 1'b0;
    #1;
    check("third_old_rd1", rdata1, 32'h01010101);

    // 6: reset wins over a same-cycle write to r9
    we = 1'b1; waddr = 5'd9; wdata = 32'h00000055;
    tick();
    we = 1'b0; raddr1 = 5'd9;
    #1;
    check("r9_pre", rdata1, 32'h00000055);
    rst = 1'b0; we = 1'b1; waddr = 5'd9; wdata = 32'h77777777;
    #1;
    check("r9_rst_forced", rdata1, 32'h0);
    tick();
    rst = 1'b1; we = 1'b0; raddr1 = 5'd9; raddr2 = 5'd31;
    #1;
    check("r9_after_rst", rdata1, 32'h0);
    check("r31_after_rst", rdata2, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- 32 x 32-bit MIPS general-purpose register file.
- Sits between the write-back stage (write port) and the decode stage (two read ports).
- Supplies the operand data that decode forwards into the ID/EX pipeline register.
- Accepts the destination address, write-enable and result that the pipeline carries back from EX/MEM/WB.
- Provides same-cycle write-to-read bypass so decode never sees stale data for a register being written back in the same cycle.

Parameters:
- DATA_W, 32, register width in bits (matches RegBus).
- ADDR_W, 5, register address width (matches RegAddrBus).
- REG_NUM, 32, number of registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  synchronous reset, active-low (asserted when 0).
- we  input  1  write enable from write-back.
- waddr  input  ADDR_W  write register index.
- wdata  input  DATA_W  write data.
- re1  input  1  read-port-1 enable from decode.
- raddr1  input  ADDR_W  read-port-1 index.
- rdata1  output  DATA_W  read-port-1 data, combinational.
- re2  input  1  read-port-2 enable.
- raddr2  input  ADDR_W  read-port-2 index.
- rdata2  output  DATA_W  read-port-2 data, combinational.

Behaviour:
- Storage: REG_NUM x DATA_W flops.
- Reset:
  - on posedge clk with rst==0, every register is cleared to ZeroWord.
  - While rst==0, rdata1 and rdata2 are forced to ZeroWord combinationally.
- Write:
  - on posedge clk with rst==1, we==1 and waddr!=0, regs[waddr] <= wdata. Visible in the register array from the next cycle.
  - Writes to index 0 are discarded; regs[0] stays 0 permanently.
- Write with rst==0 in the same cycle: reset wins, no write occurs.
- Read priority for port n (identical for both ports, evaluated combinationally):
  - 1) rst==0 -> 0.
  - 2) raddrn==0 -> 0, regardless of any write to 0.
  - 3) ren==0 -> 0.
  - 4) we==1 and waddr==raddrn -> wdata (bypass).
  - 5) otherwise regs[raddrn].
- Latency:
  - read is 0 cycles (combinational).
  - write is 1 cycle to the array; 0 cycles effective through the bypass.
- Both ports may address the same register simultaneously; both return the identical value, bypass included.
- Both ports may read while a write targets a third register; the read returns the old array contents, with no interference.
- No X propagation: every output path resolves to a defined value for any input combination once clk has toggled under reset.
- Outputs have no registered state of their own; reset value of rdata1/rdata2 is ZeroWord by rule 1.

Decomposition:
- Shared defines (existing defines.v):
  - RegBus, RegAddrBus, RegNum, RegNumLog2, ZeroWord.
  - WriteEnable/WriteDisable, ReadEnable/ReadDisable.
  - NOPRegAddr (5'b00000).
- No RstEnable reuse: this block's reset level is active-low. Add RstnEnable (1'b0) to defines.
- Natural sub-module: regfile_rport, one combinational read-port mux implementing rules 1-5. Instantiated twice, parameterised by DATA_W/ADDR_W.
- Array and write logic stay in regfile.

Test Plan:
1. Hold rst=0 for 2 cycles with we=1, waddr=5, wdata=32'hDEADBEEF -> after release, re1=1, raddr1=5 returns 0. rdata1/rdata2 are 0 throughout reset.
2. Release reset; write reg 3 = 32'h12345678, next cycle we=0, raddr1=3, re1=1 -> rdata1=32'h12345678. With re1=0 -> rdata1=0.
3. we=1, waddr=7, wdata=32'hA5A5A5A5 while raddr1=7, raddr2=7, both enabled, same cycle -> rdata1=rdata2=32'hA5A5A5A5 before the clock edge. Same value after the edge with we=0.
4. Write waddr=0, wdata=32'hFFFFFFFF -> same cycle and following cycle, raddr1=0 returns 0 (no bypass to r0).
5. Write all 31 non-zero registers with value = index*32'h01010101, then read every pair (i, 31-i) on both ports -> each port returns its own index pattern, r0 returns 0.
6. rst=0 in the same cycle as we=1, waddr=9 (reg 9 previously 32'h55) -> next cycle with rst=1, reg 9 reads 0.
